// File: rtl/alu_result_buffer.sv
// First-word fall-through buffer for ALU results: stores data, carry, zero flag and opcode,
// with a sticky overflow flag when a result is offered while full.
module alu_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH:0]             in_result,
  input  logic [2:0]                 in_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic [2:0]                 out_op,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_data  [DEPTH];
  logic             mem_carry [DEPTH];
  logic             mem_zero  [DEPTH];
  logic [2:0]       mem_op    [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          push, pop;

  // in_ready depends only on stored count, never on out_ready
  always_comb begin
    in_ready  = (cnt < FULL);
    out_valid = (cnt != '0);
    push      = in_valid && in_ready && !clr;
    pop       = out_valid && out_ready && !clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (in_valid && !in_ready) ovf <= 1'b1;
    end
  end

  // Storage is not reset; stale contents are masked while out_valid is low
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= in_result[WIDTH-1:0];
      mem_carry[wr_ptr] <= in_result[WIDTH];
      mem_zero[wr_ptr]  <= ~|in_result[WIDTH-1:0];
      mem_op[wr_ptr]    <= in_sel;
    end
  end

  always_comb begin
    out_data  = '0;
    out_carry = 1'b0;
    out_zero  = 1'b0;
    out_op    = '0;
    if (out_valid) begin
      out_data  = mem_data[rd_ptr];
      out_carry = mem_carry[rd_ptr];
      out_zero  = mem_zero[rd_ptr];
      out_op    = mem_op[rd_ptr];
    end
  end

  assign count   = cnt;
  assign ovf_err = ovf;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed self-checking bench for alu_result_buffer (WIDTH=4, DEPTH=4).
module tb_alu_result_buffer;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_result;
  logic [2:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_carry;
  logic       out_zero;
  logic [2:0] out_op;
  logic [2:0] count;
  logic       ovf_err;

  int unsigned assert_cnt = 0;
  int unsigned fail_cnt   = 0;

  logic [7:0] sb_q[$];
  logic [7:0] head;

  alu_result_buffer #(.WIDTH(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_op    (out_op),
    .count     (count),
    .ovf_err   (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, then return inputs to idle
  task automatic cyc(input logic iv, input logic [4:0] res, input logic [2:0] sel,
                     input logic ordy, input logic c);
    in_valid  = iv;
    in_result = res;
    in_sel    = sel;
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_sel = '0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_ovf", 32'(ovf_err), 0);
    rst_n = 1'b1;
    #5;

    // single push
    cyc(1'b1, 5'b01100, 3'b000, 1'b0, 1'b0);
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 32'hC);
    check("single_carry", 32'(out_carry), 0);
    check("single_zero", 32'(out_zero), 0);
    check("single_op", 32'(out_op), 0);
    check("single_count", 32'(count), 1);
    cyc(1'b0, 5'b0, 3'b0, 1'b1, 1'b0);
    check("pop_count", 32'(count), 0);
    check("empty_data_masked", 32'(out_data), 0);
    cyc(1'b0, 5'b0, 3'b0, 1'b1, 1'b0);
    check("empty_pop_count", 32'(count), 0);

    // carry and zero
    cyc(1'b1, 5'b10000, 3'b000, 1'b0, 1'b0);
    check("cz_data", 32'(out_data), 0);
    check("cz_carry", 32'(out_carry), 1);
    check("cz_zero", 32'(out_zero), 1);
    cyc(1'b0, 5'b0, 3'b0, 1'b1, 1'b0);
    check("cz_zero_masked", 32'(out_zero), 0);

    // fill and overflow
    cyc(1'b1, 5'h01, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 5'h12, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 5'h03, 3'd3, 1'b0, 1'b0);
    cyc(1'b1, 5'h14, 3'd4, 1'b0, 1'b0);
    check("full_count", 32'(count), 4);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_ovf_before", 32'(ovf_err), 0);
    cyc(1'b1, 5'h1F, 3'd7, 1'b0, 1'b0);
    check("ovf_set", 32'(ovf_err), 1);
    check("ovf_count", 32'(count), 4);
    check("pop1_data", 32'(out_data), 1);
    check("pop1_op", 32'(out_op), 1);
    cyc(1'b0, 5'b0, 3'b0, 1'b1, 1'b0);
    check("pop2_data", 32'(out_data), 2);
    check("pop2_carry", 32'(out_carry), 1);
    check("pop2_op", 32'(out_op), 2);
    cyc(1'b0, 5'b0, 3'b0, 1'b1, 1'b0);
    check("pop3_data", 32'(out_data), 3);
    check("pop3_op", 32'(out_op), 3);
    cyc(1'b0, 5'b0, 3'b0, 1'b1, 1'b0);
    check("pop4_data", 32'(out_data), 4);
    check("pop4_op", 32'(out_op), 4);
    cyc(1'b0, 5'b0, 3'b0, 1'b1, 1'b0);
    check("drained_count", 32'(count), 0);
    check("ovf_sticky", 32'(ovf_err), 1);

    // clear with simultaneous push
    cyc(1'b1, 5'h05, 3'd5, 1'b0, 1'b0);
    cyc(1'b1, 5'h06, 3'd6, 1'b0, 1'b0);
    cyc(1'b1, 5'h07, 3'd7, 1'b0, 1'b0);
    check("preclr_count", 32'(count), 3);
    cyc(1'b1, 5'h08, 3'd0, 1'b0, 1'b1);
    check("clr_count", 32'(count), 0);
    check("clr_ovf", 32'(ovf_err), 0);
    check("clr_out_valid", 32'(out_valid), 0);

    // simultaneous push and pop, then a wrapping stream
    cyc(1'b1, 5'h0A, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 5'h0B, 3'd2, 1'b0, 1'b0);
    check("sim_pre_count", 32'(count), 2);
    cyc(1'b1, 5'h0C, 3'd3, 1'b1, 1'b0);
    check("sim_count", 32'(count), 2);
    check("sim_head", 32'(out_data), 32'hB);
    sb_q.push_back({3'd2, 5'h0B});
    sb_q.push_back({3'd3, 5'h0C});
    for (int i = 0; i < 10; i++) begin
      head = sb_q.pop_front();
      check("stream_data", 32'(out_data), 32'(head[3:0]));
      check("stream_op", 32'(out_op), 32'(head[7:5]));
      sb_q.push_back({3'(i), 5'(i + 16)});
      cyc(1'b1, 5'(i + 16), 3'(i), 1'b1, 1'b0);
      check("stream_count", 32'(count), 2);
    end
    head = sb_q.pop_front();
    check("stream_tail1_data", 32'(out_data), 32'(head[3:0]));
    check("stream_tail1_carry", 32'(out_carry), 1);
    cyc(1'b0, 5'b0, 3'b0, 1'b1, 1'b0);
    head = sb_q.pop_front();
    check("stream_tail2_data", 32'(out_data), 32'(head[3:0]));
    check("stream_tail2_op", 32'(out_op), 32'(head[7:5]));
    cyc(1'b0, 5'b0, 3'b0, 1'b1, 1'b0);
    check("stream_empty", 32'(out_valid), 0);

    // async reset between edges
    cyc(1'b1, 5'h11, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 5'h12, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 5'h13, 3'd3, 1'b0, 1'b0);
    check("prerst_count", 32'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_out_op", 32'(out_op), 0);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 5'b00011, 3'd6, 1'b0, 1'b0);
    check("post_rst_data", 32'(out_data), 3);
    check("post_rst_op", 32'(out_op), 6);
    check("post_rst_count", 32'(count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
